// File: rtl/nano_pkg.sv
// Shared constants for the nano processor: opcodes, FSM encoding and instruction fields.
package nano_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned IMM_W   = 8;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 9;
    localparam int unsigned RS1_MSB = 8;
    localparam int unsigned RS1_LSB = 6;
    localparam int unsigned RS2_MSB = 5;
    localparam int unsigned RS2_LSB = 3;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_LDI  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_LOAD_IR = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

endpackage

// File: rtl/nano_alu.sv
// Combinational ALU: ADD/SUB with carry/borrow, bitwise logic, pass-through of a otherwise.
module nano_alu
    import nano_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    always_comb begin
        result = a;
        carry  = 1'b0;
        case (op)
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle fetch/decode/execute controller driving the 8x8 register file.
module unidade_controle
    import nano_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [PC_W-1:0]     pc,
    output logic [REG_AW-1:0]   addR1,
    output logic [REG_AW-1:0]   addR2,
    output logic [REG_AW-1:0]   addWr,
    output logic                wrEn,
    output logic [DATA_W-1:0]   dadoWr,
    input  logic [DATA_W-1:0]   dadoR1,
    input  logic [DATA_W-1:0]   dadoR2,
    output logic                flag_z,
    output logic                flag_c,
    output logic                halted
);

    logic [STATE_W-1:0] r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_dado;
    logic               r_z;
    logic               r_c;
    logic               r_halted;

    logic [STATE_W-1:0] w_state_next;
    logic [INSTR_W-1:0] w_ir_next;
    logic [PC_W-1:0]    w_pc_next;
    logic [DATA_W-1:0]  w_dado_next;
    logic               w_z_next;
    logic               w_c_next;
    logic               w_halted_next;

    logic [OP_W-1:0]    w_op;
    logic [IMM_W-1:0]   w_imm;
    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_target;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_c;
    logic               w_alu_z;

    assign w_op     = r_ir[OP_MSB:OP_LSB];
    assign w_imm    = r_ir[IMM_MSB:IMM_LSB];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = PC_W'(w_imm);

    nano_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (dadoR1),
        .b      (dadoR2),
        .op     (w_op),
        .result (w_alu_res),
        .carry  (w_alu_c),
        .zero   (w_alu_z)
    );

    // State register; reset wins over the stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_pc     <= PC_W'(RESET_PC);
            r_dado   <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_halted <= 1'b0;
        end else if (en) begin
            r_state  <= w_state_next;
            r_ir     <= w_ir_next;
            r_pc     <= w_pc_next;
            r_dado   <= w_dado_next;
            r_z      <= w_z_next;
            r_c      <= w_c_next;
            r_halted <= w_halted_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_next  = r_state;
        w_ir_next     = r_ir;
        w_pc_next     = r_pc;
        w_dado_next   = r_dado;
        w_z_next      = r_z;
        w_c_next      = r_c;
        w_halted_next = r_halted;
        case (r_state)
            S_FETCH:   w_state_next = S_LOAD_IR;
            S_LOAD_IR: begin
                w_ir_next    = instr_in;
                w_state_next = S_DECODE;
            end
            S_DECODE:  w_state_next = S_EXEC;
            S_EXEC: begin
                case (w_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        w_dado_next  = w_alu_res;
                        w_z_next     = w_alu_z;
                        w_c_next     = w_alu_c;
                        w_state_next = S_WB;
                    end
                    OP_LDI: begin
                        w_dado_next  = DATA_W'(w_imm);
                        w_state_next = S_WB;
                    end
                    OP_MOV: begin
                        w_dado_next  = dadoR1;
                        w_state_next = S_WB;
                    end
                    OP_JMP: begin
                        w_pc_next    = w_target;
                        w_state_next = S_FETCH;
                    end
                    OP_BEQZ: begin
                        w_pc_next    = r_z ? w_target : w_pc_inc;
                        w_state_next = S_FETCH;
                    end
                    OP_HLT: begin
                        w_halted_next = 1'b1;
                        w_state_next  = S_HALT;
                    end
                    default: begin
                        w_pc_next    = w_pc_inc;
                        w_state_next = S_FETCH;
                    end
                endcase
            end
            S_WB: begin
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_FETCH;
        endcase
    end

    // Write strobe is decoded from state and suppressed by stall or reset.
    assign wrEn   = en & ~rst & (r_state == S_WB);
    assign pc     = r_pc;
    assign addR1  = r_ir[RS1_MSB:RS1_LSB];
    assign addR2  = r_ir[RS2_MSB:RS2_LSB];
    assign addWr  = r_ir[RD_MSB:RD_LSB];
    assign dadoWr = r_dado;
    assign flag_z = r_z;
    assign flag_c = r_c;
    assign halted = r_halted;

endmodule
